blackjack_game_fsm: RTL and testbench

- Sequential game engine for one round of blackjack: dealer vs one player.
- Requests cards from the upstream card source over a valid/request handshake.
- Accumulates both hands with soft-ace scoring and reacts to player start/hit/stand pulses.
- Drives player_hand, dealer_hand and game_state straight into the seven-segment output controller, which sits directly downstream.

---
 rtl/blackjack_game_fsm.sv | 208 ++++++++++++++++++++
 tb/tb_blackjack_game_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_game_fsm.sv
// One-round blackjack engine: deals from an upstream card source, scores both
// hands with soft-ace totals and resolves the round against a single player.
module blackjack_game_fsm #(
  parameter int DEALER_STAND       = 17,
  parameter bit DEALER_HITS_SOFT17 = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  output logic       card_req,
  output logic [4:0] player_hand,
  output logic [4:0] dealer_hand,
  output logic [3:0] game_state
);

  localparam logic [3:0] S_RESET       = 4'd0;
  localparam logic [3:0] S_DEAL_PLAYER = 4'd1;
  localparam logic [3:0] S_DEAL_DEALER = 4'd2;
  localparam logic [3:0] S_PLAYER_TURN = 4'd3;
  localparam logic [3:0] S_DEALER_TURN = 4'd4;
  localparam logic [3:0] S_RESULT_WIN  = 4'd5;
  localparam logic [3:0] S_RESULT_LOSE = 4'd6;
  localparam logic [3:0] S_RESULT_TIE  = 4'd7;

  localparam logic [4:0] STAND_AT = 5'(DEALER_STAND);

  // Handshake: a card moves when card_req and card_valid are both high and
  // card_value is 1..10. card_req is registered, drops for the cycle after
  // every accepted card (the evaluation cycle) and is raised again only when
  // that evaluation decides another card is needed.

  function automatic logic is_soft(input logic [4:0] hard, input logic ace);
    return ace && (hard <= 5'd11);
  endfunction

  function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
    return is_soft(hard, ace) ? hard + 5'd10 : hard;
  endfunction

  logic [3:0] state, state_next;
  logic [4:0] p_hard, p_hard_next;
  logic [4:0] d_hard, d_hard_next;
  logic       p_ace, p_ace_next;
  logic       d_ace, d_ace_next;
  logic [1:0] cnt, cnt_next;
  logic       req, req_next;

  logic       card_ok;
  logic       accept;
  logic       card_is_ace;
  logic [4:0] card_pts;
  logic [4:0] p_best;
  logic [4:0] d_best;
  logic       d_soft;
  logic       dealer_draws;
  logic       in_result;
  logic       restart;

  assign card_ok     = (card_value != 4'd0) && (card_value <= 4'd10);
  assign accept      = req && card_valid && card_ok;
  assign card_is_ace = (card_value == 4'd1);
  assign card_pts    = {1'b0, card_value};

  assign p_best = best_total(p_hard, p_ace);
  assign d_best = best_total(d_hard, d_ace);
  assign d_soft = is_soft(d_hard, d_ace);

  assign dealer_draws = (d_best < STAND_AT) ||
                        (DEALER_HITS_SOFT17 && (d_best == 5'd17) && d_soft);

  assign in_result = (state == S_RESULT_WIN) || (state == S_RESULT_LOSE) ||
                     (state == S_RESULT_TIE);
  assign restart   = start && ((state == S_RESET) || in_result);

  always_comb begin
    state_next  = state;
    p_hard_next = p_hard;
    d_hard_next = d_hard;
    p_ace_next  = p_ace;
    d_ace_next  = d_ace;
    cnt_next    = cnt;
    req_next    = req;

    if (restart) begin
      p_hard_next = 5'd0;
      d_hard_next = 5'd0;
      p_ace_next  = 1'b0;
      d_ace_next  = 1'b0;
      cnt_next    = 2'd0;
      req_next    = 1'b0;
      state_next  = S_DEAL_PLAYER;
    end else begin
      case (state)
        S_DEAL_PLAYER: begin
          if (accept) begin
            p_hard_next = p_hard + card_pts;
            p_ace_next  = p_ace | card_is_ace;
            cnt_next    = cnt + 2'd1;
            req_next    = 1'b0;
          end else if (!req) begin
            if (cnt == 2'd2) begin
              cnt_next   = 2'd0;
              state_next = S_DEAL_DEALER;
            end else begin
              req_next = 1'b1;
            end
          end
        end

        S_DEAL_DEALER: begin
          if (accept) begin
            d_hard_next = d_hard + card_pts;
            d_ace_next  = d_ace | card_is_ace;
            cnt_next    = cnt + 2'd1;
            req_next    = 1'b0;
          end else if (!req) begin
            if (cnt == 2'd1) begin
              cnt_next   = 2'd0;
              state_next = S_PLAYER_TURN;
            end else begin
              req_next = 1'b1;
            end
          end
        end

        S_PLAYER_TURN: begin
          // While a hit card is outstanding, further pulses are dropped.
          if (req) begin
            if (accept) begin
              p_hard_next = p_hard + card_pts;
              p_ace_next  = p_ace | card_is_ace;
              req_next    = 1'b0;
            end
          end else if (p_best > 5'd21) begin
            state_next = S_RESULT_LOSE;
          end else if (p_best == 5'd21) begin
            state_next = S_DEALER_TURN;
          end else if (stand) begin
            state_next = S_DEALER_TURN;
          end else if (hit) begin
            req_next = 1'b1;
          end
        end

        S_DEALER_TURN: begin
          if (req) begin
            if (accept) begin
              d_hard_next = d_hard + card_pts;
              d_ace_next  = d_ace | card_is_ace;
              req_next    = 1'b0;
            end
          end else if (dealer_draws) begin
            req_next = 1'b1;
          end else if (d_best > 5'd21) begin
            state_next = S_RESULT_WIN;
          end else if (p_best > d_best) begin
            state_next = S_RESULT_WIN;
          end else if (p_best < d_best) begin
            state_next = S_RESULT_LOSE;
          end else begin
            state_next = S_RESULT_TIE;
          end
        end

        S_RESET, S_RESULT_WIN, S_RESULT_LOSE, S_RESULT_TIE: begin
          req_next = 1'b0;
        end

        default: begin
          state_next = S_RESET;
          req_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_RESET;
      p_hard      <= 5'd0;
      d_hard      <= 5'd0;
      p_ace       <= 1'b0;
      d_ace       <= 1'b0;
      cnt         <= 2'd0;
      req         <= 1'b0;
      player_hand <= 5'd0;
      dealer_hand <= 5'd0;
    end else begin
      state       <= state_next;
      p_hard      <= p_hard_next;
      d_hard      <= d_hard_next;
      p_ace       <= p_ace_next;
      d_ace       <= d_ace_next;
      cnt         <= cnt_next;
      req         <= req_next;
      player_hand <= best_total(p_hard_next, p_ace_next);
      dealer_hand <= best_total(d_hard_next, d_ace_next);
    end
  end

  assign card_req   = req;
  assign game_state = state;

endmodule

// File: tb/tb_blackjack_game_fsm.sv
// Directed bench for blackjack_game_fsm: a default instance plus a
// dealer-hits-soft-17 instance driven by the same card source and pulses.
module tb_blackjack_game_fsm;

  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_PTURN = 4'd3;
  localparam logic [3:0] ST_DTURN = 4'd4;
  localparam logic [3:0] ST_WIN   = 4'd5;
  localparam logic [3:0] ST_LOSE  = 4'd6;
  localparam logic [3:0] ST_TIE   = 4'd7;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] card_value = 4'd0;

  logic       card_req, req_s17;
  logic [4:0] player_hand, dealer_hand, player_s17, dealer_s17;
  logic [3:0] game_state, state_s17;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  blackjack_game_fsm dut (
    .clk(clk), .reset_n(reset_n), .start(start), .hit(hit), .stand(stand),
    .card_valid(card_valid), .card_value(card_value), .card_req(card_req),
    .player_hand(player_hand), .dealer_hand(dealer_hand), .game_state(game_state)
  );

  blackjack_game_fsm #(.DEALER_STAND(17), .DEALER_HITS_SOFT17(1'b1)) dut_s17 (
    .clk(clk), .reset_n(reset_n), .start(start), .hit(hit), .stand(stand),
    .card_valid(card_valid), .card_value(card_value), .card_req(req_s17),
    .player_hand(player_s17), .dealer_hand(dealer_s17), .game_state(state_s17)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic req_of(input int sel);
    return (sel == 2) ? req_s17 : card_req;
  endfunction

  function automatic logic [3:0] state_of(input int sel);
    return (sel == 2) ? state_s17 : game_state;
  endfunction

  function automatic logic [4:0] hand_of(input int sel);
    if (sel == 0) return player_hand;
    if (sel == 1) return dealer_hand;
    return dealer_s17;
  endfunction

  task automatic pulse(input int which);
    start = (which == 0);
    hit   = (which == 1) || (which == 3);
    stand = (which == 2) || (which == 3);
    tick();
    start = 1'b0;
    hit   = 1'b0;
    stand = 1'b0;
  endtask

  task automatic wait_req(input int sel, input string tag);
    int n = 0;
    while (req_of(sel) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, {31'd0, req_of(sel)}, 32'd1);
  endtask

  task automatic wait_state(input int sel, input logic [3:0] target, input string tag);
    int n = 0;
    while (state_of(sel) !== target && n < 40) begin
      tick();
      n++;
    end
    check(tag, {28'd0, state_of(sel)}, {28'd0, target});
  endtask

  // sel 0: player of main DUT, 1: dealer of main DUT, 2: dealer of soft-17 DUT
  task automatic feed(input int sel, input logic [3:0] value, input logic [4:0] exp_hand,
                      input string tag);
    logic [4:0] want;
    exp_q.push_back(exp_hand);
    wait_req(sel, {tag, "_req"});
    card_value = value;
    card_valid = 1'b1;
    tick();
    card_valid = 1'b0;
    card_value = 4'd0;
    want = exp_q.pop_front();
    check(tag, {27'd0, hand_of(sel)}, {27'd0, want});
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    reset_n = 1'b1;
    check("rst_state", {28'd0, game_state}, 32'd0);
    check("rst_player", {27'd0, player_hand}, 32'd0);
    check("rst_dealer", {27'd0, dealer_hand}, 32'd0);
    check("rst_req", {31'd0, card_req}, 32'd0);

    // Player 10,6 vs dealer 9, hit busts with 9
    pulse(0);
    feed(0, 4'd10, 5'd10, "bust_p1");
    feed(0, 4'd6, 5'd16, "bust_p2");
    feed(1, 4'd9, 5'd9, "bust_d1");
    wait_state(0, ST_PTURN, "bust_pturn");
    pulse(1);
    feed(0, 4'd9, 5'd25, "bust_p3");
    wait_state(0, ST_LOSE, "bust_lose");
    repeat (3) tick();
    check("bust_req_idle", {31'd0, card_req}, 32'd0);
    check("bust_dealer", {27'd0, dealer_hand}, 32'd9);
    check("bust_player", {27'd0, player_hand}, 32'd25);

    // Player 18 stands, dealer 10+6+10 busts
    pulse(0);
    check("win_cleared", {27'd0, player_hand}, 32'd0);
    feed(0, 4'd10, 5'd10, "dbust_p1");
    feed(0, 4'd8, 5'd18, "dbust_p2");
    feed(1, 4'd10, 5'd10, "dbust_d1");
    wait_state(0, ST_PTURN, "dbust_pturn");
    pulse(2);
    feed(1, 4'd6, 5'd16, "dbust_d2");
    feed(1, 4'd10, 5'd26, "dbust_d3");
    wait_state(0, ST_WIN, "dbust_win");
    check("dbust_player", {27'd0, player_hand}, 32'd18);
    check("dbust_dealer", {27'd0, dealer_hand}, 32'd26);

    // Soft 21 auto-stands, dealer reaches 21 with an ace: tie
    pulse(0);
    feed(0, 4'd1, 5'd11, "tie_p1");
    feed(0, 4'd10, 5'd21, "tie_p2");
    feed(1, 4'd10, 5'd10, "tie_d1");
    wait_state(0, ST_DTURN, "tie_autostand");
    feed(1, 4'd1, 5'd21, "tie_d2");
    wait_state(0, ST_TIE, "tie_result");
    check("tie_player", {27'd0, player_hand}, 32'd21);

    // Dealer soft 17: default stands and loses to 18, soft-17 variant draws a 4
    pulse(0);
    feed(0, 4'd10, 5'd10, "s17_p1");
    feed(0, 4'd8, 5'd18, "s17_p2");
    feed(1, 4'd1, 5'd11, "s17_d1");
    wait_state(0, ST_PTURN, "s17_pturn");
    pulse(2);
    feed(1, 4'd6, 5'd17, "s17_d2");
    check("s17_variant_dealer", {27'd0, dealer_s17}, 32'd17);
    wait_state(0, ST_WIN, "s17_stand_win");
    check("s17_stand_noreq", {31'd0, card_req}, 32'd0);
    feed(2, 4'd4, 5'd21, "s17_hit_d3");
    wait_state(2, ST_LOSE, "s17_hit_lose");
    check("s17_stand_dealer", {27'd0, dealer_hand}, 32'd17);
    check("s17_stand_state", {28'd0, game_state}, {28'd0, ST_WIN});

    // Handshake stalls, illegal values and pulse handling in the player turn
    pulse(0);
    feed(0, 4'd10, 5'd10, "hs_p1");
    feed(0, 4'd5, 5'd15, "hs_p2");
    feed(1, 4'd7, 5'd7, "hs_d1");
    wait_state(0, ST_PTURN, "hs_pturn");
    pulse(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hs_hold_req", {31'd0, card_req}, 32'd1);
    end
    check("hs_hold_state", {28'd0, game_state}, {28'd0, ST_PTURN});
    check("hs_hold_player", {27'd0, player_hand}, 32'd15);
    card_valid = 1'b1;
    card_value = 4'd0;
    tick();
    check("hs_zero_req", {31'd0, card_req}, 32'd1);
    check("hs_zero_player", {27'd0, player_hand}, 32'd15);
    card_value = 4'd11;
    tick();
    check("hs_big_req", {31'd0, card_req}, 32'd1);
    check("hs_big_player", {27'd0, player_hand}, 32'd15);
    card_valid = 1'b0;
    card_value = 4'd0;
    pulse(1);
    feed(0, 4'd3, 5'd18, "hs_p3");
    repeat (2) tick();
    check("hs_no_queue_req", {31'd0, card_req}, 32'd0);
    check("hs_no_queue_state", {28'd0, game_state}, {28'd0, ST_PTURN});
    pulse(3);
    check("hs_hitstand_state", {28'd0, game_state}, {28'd0, ST_DTURN});
    check("hs_hitstand_player", {27'd0, player_hand}, 32'd18);

    // Reset while the dealer is waiting on a card
    wait_req(1, "rst_mid_req");
    check("rst_mid_pre_state", {28'd0, game_state}, {28'd0, ST_DTURN});
    reset_n = 1'b0;
    tick();
    check("rst_mid_state", {28'd0, game_state}, {28'd0, ST_RESET});
    check("rst_mid_req0", {31'd0, card_req}, 32'd0);
    check("rst_mid_player", {27'd0, player_hand}, 32'd0);
    check("rst_mid_dealer", {27'd0, dealer_hand}, 32'd0);
    reset_n = 1'b1;
    card_valid = 1'b1;
    card_value = 4'd5;
    repeat (2) tick();
    check("rst_ign_req", {31'd0, card_req}, 32'd0);
    check("rst_ign_player", {27'd0, player_hand}, 32'd0);
    check("rst_ign_dealer", {27'd0, dealer_hand}, 32'd0);
    check("rst_ign_state", {28'd0, game_state}, {28'd0, ST_RESET});
    card_valid = 1'b0;
    card_value = 4'd0;
    pulse(0);
    feed(0, 4'd2, 5'd2, "rst_new_p1");
    check("rst_new_dealer", {27'd0, dealer_hand}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
